// File: rtl/nco_ddc_mixer.sv
// Complex down-conversion mixer: multiplies a real ADC stream by NCO cos/-sin,
// then rounds and saturates to ow bits through a 3-stage, clken-gated pipeline.
module nco_ddc_mixer #(
  parameter int adw = 16,
  parameter int mpr = 16,
  parameter int ow  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic [adw-1:0]        adc_data,
  input  logic                  adc_valid,
  input  logic [mpr-1:0]        fsin_i,
  input  logic [mpr-1:0]        fcos_i,
  input  logic                  nco_valid,
  input  logic                  sat_clr,
  output logic [ow-1:0]         mix_i,
  output logic [ow-1:0]         mix_q,
  output logic                  out_valid,
  output logic                  sat_flag,
  output logic [15:0]           sat_count
);

  localparam int pw = adw + mpr;
  localparam int sh = adw + mpr - 1 - ow;

  localparam logic signed [pw-1:0] rnd   = pw'(1) << (sh - 1);
  localparam logic signed [pw-1:0] r_max = (pw'(1) << (ow - 1)) - pw'(1);
  localparam logic signed [pw-1:0] r_min = -(pw'(1) << (ow - 1));

  // S1: registered inputs
  logic                    v1_q, v1_d;
  logic signed [adw-1:0]   adc_q, adc_d;
  logic signed [mpr-1:0]   sin_q, sin_d;
  logic signed [mpr-1:0]   cos_q, cos_d;
  // S2: full-width products
  logic                    v2_q, v2_d;
  logic signed [pw-1:0]    pi_q, pi_d;
  logic signed [pw-1:0]    pq_q, pq_d;
  // S3: output registers and saturation status
  logic                    v3_q, v3_d;
  logic [ow-1:0]           mix_i_q, mix_i_d;
  logic [ow-1:0]           mix_q_q, mix_q_d;
  logic                    sat_flag_q, sat_flag_d;
  logic [15:0]             sat_count_q, sat_count_d;

  logic                    accept;
  logic signed [pw-1:0]    adc_x, sin_x, cos_x;
  logic signed [pw-1:0]    prod_i, prod_q;
  logic signed [pw-1:0]    round_i, round_q;
  logic                    sat_i, sat_q, sat_hit;
  logic [ow-1:0]           res_i, res_q;

  // Product datapath. The I/Q magnitudes never exceed 2^(pw-2), so the
  // negation of Q and the rounding offset both fit in pw bits.
  always_comb begin
    adc_x   = pw'(adc_q);
    sin_x   = pw'(sin_q);
    cos_x   = pw'(cos_q);
    prod_i  = adc_x * cos_x;
    prod_q  = -(adc_x * sin_x);
    round_i = (pi_q + rnd) >>> sh;
    round_q = (pq_q + rnd) >>> sh;
    sat_i   = (round_i > r_max) || (round_i < r_min);
    sat_q   = (round_q > r_max) || (round_q < r_min);
    res_i   = (round_i > r_max) ? r_max[ow-1:0] :
              (round_i < r_min) ? r_min[ow-1:0] : round_i[ow-1:0];
    res_q   = (round_q > r_max) ? r_max[ow-1:0] :
              (round_q < r_min) ? r_min[ow-1:0] : round_q[ow-1:0];
  end

  // NOTE: every _d defaults to its _q first, so no path through this block
  // leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    v1_d        = v1_q;
    adc_d       = adc_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    v2_d        = v2_q;
    pi_d        = pi_q;
    pq_d        = pq_q;
    v3_d        = v3_q;
    mix_i_d     = mix_i_q;
    mix_q_d     = mix_q_q;
    sat_flag_d  = sat_flag_q;
    sat_count_d = sat_count_q;

    accept  = clken && adc_valid && nco_valid;
    sat_hit = clken && v2_q && (sat_i || sat_q);

    if (clken) begin
      v1_d = accept;
      if (accept) begin
        adc_d = adc_data;
        sin_d = fsin_i;
        cos_d = fcos_i;
      end
      v2_d = v1_q;
      if (v1_q) begin
        pi_d = prod_i;
        pq_d = prod_q;
      end
      v3_d = v2_q;
      if (v2_q) begin
        mix_i_d = res_i;
        mix_q_d = res_q;
      end
    end

    // A clear that lands on a saturating load keeps that one new event.
    if (sat_clr) begin
      sat_flag_d  = sat_hit;
      sat_count_d = sat_hit ? 16'd1 : 16'd0;
    end else if (sat_hit) begin
      sat_flag_d = 1'b1;
      if (sat_count_q != 16'hffff) sat_count_d = sat_count_q + 16'd1;
    end
  end

  // NOTE: the datapath registers are reset along with the valid bits so the
  // outputs read as zero during reset; non-blocking assignments keep every
  // stage sampling the pre-edge value of the stage before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      adc_q       <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      v2_q        <= 1'b0;
      pi_q        <= '0;
      pq_q        <= '0;
      v3_q        <= 1'b0;
      mix_i_q     <= '0;
      mix_q_q     <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      v1_q        <= v1_d;
      adc_q       <= adc_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      v2_q        <= v2_d;
      pi_q        <= pi_d;
      pq_q        <= pq_d;
      v3_q        <= v3_d;
      mix_i_q     <= mix_i_d;
      mix_q_q     <= mix_q_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign mix_i     = mix_i_q;
  assign mix_q     = mix_q_q;
  assign out_valid = v3_q;
  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_nco_ddc_mixer.sv
// Directed self-checking bench for nco_ddc_mixer: latency, rounding,
// saturation/clear, clken stalls, bubbles and mid-flight reset.
module tb_nco_ddc_mixer;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clken;
  logic [15:0]        adc_data;
  logic               adc_valid;
  logic [15:0]        fsin_i;
  logic [15:0]        fcos_i;
  logic               nco_valid;
  logic               sat_clr;
  logic signed [15:0] mix_i;
  logic signed [15:0] mix_q;
  logic               out_valid;
  logic               sat_flag;
  logic [15:0]        sat_count;

  int checks = 0;
  int errors = 0;

  nco_ddc_mixer #(.adw(16), .mpr(16), .ow(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .fsin_i    (fsin_i),
    .fcos_i    (fcos_i),
    .nco_valid (nco_valid),
    .sat_clr   (sat_clr),
    .mix_i     (mix_i),
    .mix_q     (mix_q),
    .out_valid (out_valid),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int a, input int c, input int s);
    adc_data  = 16'(a);
    fcos_i    = 16'(c);
    fsin_i    = 16'(s);
    adc_valid = 1'b1;
    nco_valid = 1'b1;
  endtask

  task automatic idle();
    adc_valid = 1'b0;
    nco_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[$];
    int n_out;
    int exp_k;
    logic prev_ov;
    logic signed [15:0] prev_i;

    reset_n = 1'b0; clken = 1'b1; sat_clr = 1'b0;
    adc_data = '0; fcos_i = '0; fsin_i = '0; idle();
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_mix_i", mix_i, 0);
    check("rst_mix_q", mix_q, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_sat_count", sat_count, 0);
    reset_n = 1'b1;
    step(); step();

    // Basic gain path and 3-edge latency
    set_sample(16384, 32767, 0);
    step(); idle();
    step(); check("lat_edge2_valid", out_valid, 0);
    step();
    check("basic_valid", out_valid, 1);
    check("basic_mix_i", mix_i, 16384);
    check("basic_mix_q", mix_q, 0);
    check("basic_sat_flag", sat_flag, 0);
    step();
    check("basic_strobe_len", out_valid, 0);
    check("basic_hold_i", mix_i, 16384);

    // Rounding, back-to-back
    set_sample(1, 16384, 16384); step();
    set_sample(1, 16383, 0);     step();
    idle(); step();
    check("rnd_a_valid", out_valid, 1);
    check("rnd_a_mix_i", mix_i, 1);
    check("rnd_a_mix_q", mix_q, 0);
    step();
    check("rnd_b_valid", out_valid, 1);
    check("rnd_b_mix_i", mix_i, 0);
    check("rnd_b_mix_q", mix_q, 0);
    step();
    check("rnd_end_valid", out_valid, 0);

    // Saturation: two consecutive clamped samples
    set_sample(-32768, -32768, -32768);
    step(); step(); idle(); step();
    check("sat_valid", out_valid, 1);
    check("sat_mix_i", mix_i, 32767);
    check("sat_mix_q", mix_q, -32768);
    check("sat_flag1", sat_flag, 1);
    check("sat_count1", sat_count, 1);
    step();
    check("sat_count2", sat_count, 2);
    step();
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    check("clr_flag", sat_flag, 0);
    check("clr_count", sat_count, 0);
    // Clear coinciding with a saturating load
    set_sample(-32768, -32768, -32768);
    step(); idle(); step();
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    check("clr_coin_valid", out_valid, 1);
    check("clr_coin_flag", sat_flag, 1);
    check("clr_coin_count", sat_count, 1);
    // Clear works with clken low
    clken = 1'b0; sat_clr = 1'b1; step();
    sat_clr = 1'b0;
    check("clr_noclk_count", sat_count, 0);
    check("clr_noclk_flag", sat_flag, 0);
    clken = 1'b1;
    step(); step(); step(); step();

    // clken toggling with continuous valid input
    fcos_i = 16'sd16384; fsin_i = 16'sd16384;
    adc_valid = 1'b1; nco_valid = 1'b1;
    n_out = 0;
    for (int i = 0; i < 16; i++) begin
      clken    = (i % 2 == 0) && (i < 12);
      adc_data = clken ? 16'(2 * (i + 10)) : 16'd1998;
      if (i >= 12) begin clken = (i % 2 == 0); adc_valid = 1'b0; end
      if (clken && adc_valid) exp_q.push_back(i + 10);
      prev_ov = out_valid;
      prev_i  = mix_i;
      step();
      if (clken) begin
        if (out_valid) begin
          n_out++;
          exp_k = (exp_q.size() > 0) ? exp_q.pop_front() : -9999;
          check("tog_mix_i", mix_i, exp_k);
          check("tog_mix_q", mix_q, -exp_k);
        end
      end else begin
        check("tog_hold_valid", out_valid, prev_ov);
        check("tog_hold_mix_i", mix_i, prev_i);
      end
    end
    clken = 1'b1; idle();
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) begin
        n_out++;
        exp_k = (exp_q.size() > 0) ? exp_q.pop_front() : -9999;
        check("tog_flush_mix_i", mix_i, exp_k);
      end
    end
    check("tog_out_count", n_out, 6);
    check("tog_queue_left", exp_q.size(), 0);

    // NCO not valid: no acceptance
    prev_i = mix_i;
    adc_data = 16'd1000; adc_valid = 1'b1; nco_valid = 1'b0;
    n_out = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) n_out++;
    end
    check("nco_inval_strobes", n_out, 0);
    check("nco_inval_hold_i", mix_i, prev_i);

    // Set sat_flag, then reset one cycle after an acceptance
    set_sample(-32768, -32768, -32768);
    step(); idle(); step(); step();
    check("pre_rst_flag", sat_flag, 1);
    set_sample(16384, 32767, 0);
    step(); idle();
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_mix_i", mix_i, 0);
    check("arst_mix_q", mix_q, 0);
    check("arst_sat_flag", sat_flag, 0);
    check("arst_sat_count", sat_count, 0);
    step();
    reset_n = 1'b1;
    n_out = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) n_out++;
    end
    check("arst_discard", n_out, 0);
    set_sample(2, 16384, 16384);
    step(); idle();
    step(); check("post_rst_edge2", out_valid, 0);
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_mix_i", mix_i, 1);
    check("post_rst_mix_q", mix_q, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
